pong_game_ctrl: RTL and testbench



---
 rtl/pong_game_ctrl_if.sv | 28 ++
 rtl/pong_game_ctrl.sv | 157 +++++++++++++++
 tb/tb_pong_game_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong datapath and its game-sequencing controller.
// The controller side (slave) consumes datapath flags and the frame tick and
// drives the freeze, state, score and rally outputs; the master side is the
// datapath/overlay view of the same wires.
interface pong_game_ctrl_if;
  logic       start;
  logic       refr_tick;
  logic       hit_left;
  logic       hit_right;
  logic       miss_left;
  logic       miss_right;
  logic       graph_still;
  logic [1:0] game_state;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [7:0] rally;
  logic [1:0] winner;

  modport slave (
    input  start, refr_tick, hit_left, hit_right, miss_left, miss_right,
    output graph_still, game_state, score_l, score_r, rally, winner
  );

  modport master (
    output start, refr_tick, hit_left, hit_right, miss_left, miss_right,
    input  graph_still, game_state, score_l, score_r, rally, winner
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game-sequencing controller: runs IDLE/SERVE/PLAY/OVER, freezes the
// datapath outside PLAY, keeps both scores and a saturating rally counter.
// Every output comes straight from a register.
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 120
) (
  input  logic              clk,
  input  logic              reset,
  pong_game_ctrl_if.slave   bus
);

  localparam logic [3:0] WIN_L   = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_L = 8'(SERVE_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SERVE = 2'b01,
    ST_PLAY  = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  state_t     state_r, state_nx_s;
  logic [3:0] score_l_r, score_l_nx_s;
  logic [3:0] score_r_r, score_r_nx_s;
  logic [7:0] rally_r, rally_nx_s;
  logic [1:0] winner_r, winner_nx_s;
  logic [7:0] timer_r, timer_nx_s;
  logic       graph_still_r;
  logic       start_q_r;
  logic       hit_q_r;
  logic       hit_any_s;
  logic       start_rise_s;
  logic       hit_rise_s;

  // Edge detectors: the history registers reset high so a level already
  // present when reset lifts is not mistaken for a fresh press or contact.
  assign hit_any_s    = bus.hit_left | bus.hit_right;
  assign start_rise_s = bus.start & ~start_q_r;
  assign hit_rise_s   = hit_any_s & ~hit_q_r;

  assign bus.game_state  = state_r;
  assign bus.graph_still = graph_still_r;
  assign bus.score_l     = score_l_r;
  assign bus.score_r     = score_r_r;
  assign bus.rally       = rally_r;
  assign bus.winner      = winner_r;

  // State, score, timer, edge-history and freeze registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      score_l_r     <= 4'd0;
      score_r_r     <= 4'd0;
      rally_r       <= 8'd0;
      winner_r      <= 2'b00;
      timer_r       <= 8'd0;
      graph_still_r <= 1'b1;
      start_q_r     <= 1'b1;
      hit_q_r       <= 1'b1;
    end else begin
      state_r       <= state_nx_s;
      score_l_r     <= score_l_nx_s;
      score_r_r     <= score_r_nx_s;
      rally_r       <= rally_nx_s;
      winner_r      <= winner_nx_s;
      timer_r       <= timer_nx_s;
      // Freeze follows the current state, so it lags a transition by a cycle.
      graph_still_r <= (state_r != ST_PLAY);
      start_q_r     <= bus.start;
      hit_q_r       <= hit_any_s;
    end
  end

  // Game flow: next state plus score/rally/winner/timer updates.
  always_comb begin
    state_nx_s   = state_r;
    score_l_nx_s = score_l_r;
    score_r_nx_s = score_r_r;
    rally_nx_s   = rally_r;
    winner_nx_s  = winner_r;
    timer_nx_s   = timer_r;

    case (state_r)
      ST_IDLE, ST_OVER: begin
        // A fresh start press begins a new game from either resting state.
        if (start_rise_s) begin
          score_l_nx_s = 4'd0;
          score_r_nx_s = 4'd0;
          rally_nx_s   = 8'd0;
          winner_nx_s  = 2'b00;
          timer_nx_s   = SERVE_L;
          state_nx_s   = ST_SERVE;
        end else begin
          state_nx_s   = state_r;
        end
      end

      ST_SERVE: begin
        // Hit and miss flags are ignored here: they may be stale from the
        // rally that just ended.
        if (bus.refr_tick) begin
          if (timer_r == 8'd1) begin
            state_nx_s = ST_PLAY;
          end else begin
            timer_nx_s = timer_r - 8'd1;
          end
        end else begin
          timer_nx_s = timer_r;
        end
      end

      ST_PLAY: begin
        // A miss is acted on in its first cycle; leaving PLAY makes a held
        // miss level score only once, and it pre-empts any same-cycle hit.
        if (bus.miss_left && bus.miss_right) begin
          rally_nx_s = 8'd0;
          timer_nx_s = SERVE_L;
          state_nx_s = ST_SERVE;
        end else if (bus.miss_left) begin
          score_r_nx_s = score_r_r + 4'd1;
          if ((score_r_r + 4'd1) == WIN_L) begin
            winner_nx_s = 2'b10;
            state_nx_s  = ST_OVER;
          end else begin
            rally_nx_s  = 8'd0;
            timer_nx_s  = SERVE_L;
            state_nx_s  = ST_SERVE;
          end
        end else if (bus.miss_right) begin
          score_l_nx_s = score_l_r + 4'd1;
          if ((score_l_r + 4'd1) == WIN_L) begin
            winner_nx_s = 2'b01;
            state_nx_s  = ST_OVER;
          end else begin
            rally_nx_s  = 8'd0;
            timer_nx_s  = SERVE_L;
            state_nx_s  = ST_SERVE;
          end
        end else if (hit_rise_s) begin
          if (rally_r != 8'hFF) begin
            rally_nx_s = rally_r + 8'd1;
          end else begin
            rally_nx_s = rally_r;
          end
        end else begin
          rally_nx_s = rally_r;
        end
      end

      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl (WIN_SCORE=3, SERVE_FRAMES=3). Stimulus
// pushes the expected output snapshot for the cycle after each edge into a
// queue; a monitor pops and compares on the falling edge of that cycle.
module tb_pong_game_ctrl;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SERVE = 2'b01;
  localparam logic [1:0] PLAY  = 2'b10;
  localparam logic [1:0] OVER  = 2'b11;

  typedef struct {
    int          cyc;
    string       nm;
    logic [20:0] val;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  exp_t q[$];

  pong_game_ctrl_if bus();

  pong_game_ctrl #(.WIN_SCORE(3), .SERVE_FRAMES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising-edge counter used to time-stamp expectations.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [20:0] actual();
    return {bus.game_state, bus.graph_still, bus.score_l, bus.score_r,
            bus.rally, bus.winner};
  endfunction

  task automatic compare(string nm, logic [20:0] act, logic [20:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got {st,gs,sl,sr,rally,win}=%h want %h", nm, act, want);
    end
  endtask

  task automatic expect_next(string nm, logic [1:0] st, logic gs,
                             logic [3:0] sl, logic [3:0] sr,
                             logic [7:0] ra, logic [1:0] w);
    exp_t e;
    e.cyc = cyc + 1;
    e.nm  = nm;
    e.val = {st, gs, sl, sr, ra, w};
    q.push_back(e);
  endtask

  // Monitor: compare every expectation due in the cycle just completed.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s missed sample cycle got %0d want %0d", e.nm, cyc, e.cyc);
      end else begin
        compare(e.nm, actual(), e.val);
      end
    end
  end

  // Three frame ticks from SERVE entry; PLAY shows right after the third.
  task automatic serve_to_play(logic [3:0] sl, logic [3:0] sr);
    for (int i = 0; i < 3; i++) begin
      bus.refr_tick = 1'b1;
      if (i == 2) expect_next("to_play", PLAY, 1'b1, sl, sr, 8'd0, 2'b00);
      @(negedge clk);
      bus.refr_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  // Watchdog so the run can never hang.
  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog cycle budget expired got %0d want <5000", cyc);
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start = 1'b1;
    bus.refr_tick = 1'b0;
    bus.hit_left = 1'b0;
    bus.hit_right = 1'b0;
    bus.miss_left = 1'b0;
    bus.miss_right = 1'b0;

    @(negedge clk);
    expect_next("in_reset", IDLE, 1'b1, 4'd0, 4'd0, 8'd0, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    // Start held through reset release must not trigger.
    for (int i = 0; i < 5; i++) begin
      expect_next("start_held", IDLE, 1'b1, 4'd0, 4'd0, 8'd0, 2'b00);
      @(negedge clk);
    end
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    expect_next("serve_entry", SERVE, 1'b1, 4'd0, 4'd0, 8'd0, 2'b00);
    @(negedge clk);
    bus.start = 1'b0;

    // Serve countdown with ticks spaced 10 cycles apart.
    for (int i = 0; i < 3; i++) begin
      bus.refr_tick = 1'b1;
      if (i == 2) expect_next("tick3_play", PLAY, 1'b1, 4'd0, 4'd0, 8'd0, 2'b00);
      else        expect_next("tick_serve", SERVE, 1'b1, 4'd0, 4'd0, 8'd0, 2'b00);
      @(negedge clk);
      bus.refr_tick = 1'b0;
      if (i == 2) begin
        expect_next("play_unfrozen", PLAY, 1'b0, 4'd0, 4'd0, 8'd0, 2'b00);
        @(negedge clk);
      end else begin
        expect_next("serve_hold", SERVE, 1'b1, 4'd0, 4'd0, 8'd0, 2'b00);
        repeat (9) @(negedge clk);
      end
    end

    // Long hit levels count once each.
    bus.hit_left = 1'b1;
    expect_next("hit_left", PLAY, 1'b0, 4'd0, 4'd0, 8'd1, 2'b00);
    @(negedge clk);
    expect_next("hit_left_held", PLAY, 1'b0, 4'd0, 4'd0, 8'd1, 2'b00);
    repeat (19) @(negedge clk);
    bus.hit_left = 1'b0;
    @(negedge clk);
    bus.hit_right = 1'b1;
    expect_next("hit_right", PLAY, 1'b0, 4'd0, 4'd0, 8'd2, 2'b00);
    repeat (20) @(negedge clk);
    bus.hit_right = 1'b0;
    @(negedge clk);

    // Held miss scores exactly once.
    bus.miss_right = 1'b1;
    expect_next("miss_right", SERVE, 1'b0, 4'd1, 4'd0, 8'd0, 2'b00);
    @(negedge clk);
    expect_next("miss_right_held", SERVE, 1'b1, 4'd1, 4'd0, 8'd0, 2'b00);
    repeat (49) @(negedge clk);
    bus.miss_right = 1'b0;
    serve_to_play(4'd1, 4'd0);

    // Simultaneous misses: no score.
    bus.miss_left = 1'b1;
    bus.miss_right = 1'b1;
    expect_next("miss_both", SERVE, 1'b0, 4'd1, 4'd0, 8'd0, 2'b00);
    @(negedge clk);
    bus.miss_left = 1'b0;
    bus.miss_right = 1'b0;
    serve_to_play(4'd1, 4'd0);

    // Miss with a same-cycle hit.
    bus.miss_right = 1'b1;
    bus.hit_left = 1'b1;
    expect_next("miss_with_hit", SERVE, 1'b0, 4'd2, 4'd0, 8'd0, 2'b00);
    @(negedge clk);
    bus.miss_right = 1'b0;
    bus.hit_left = 1'b0;
    serve_to_play(4'd2, 4'd0);

    // Right player climbs to WIN_SCORE.
    bus.miss_left = 1'b1;
    expect_next("sr1", SERVE, 1'b0, 4'd2, 4'd1, 8'd0, 2'b00);
    @(negedge clk);
    bus.miss_left = 1'b0;
    serve_to_play(4'd2, 4'd1);
    bus.miss_left = 1'b1;
    expect_next("sr2", SERVE, 1'b0, 4'd2, 4'd2, 8'd0, 2'b00);
    @(negedge clk);
    bus.miss_left = 1'b0;
    serve_to_play(4'd2, 4'd2);
    bus.hit_left = 1'b1;
    expect_next("rally_before_win", PLAY, 1'b0, 4'd2, 4'd2, 8'd1, 2'b00);
    @(negedge clk);
    bus.hit_left = 1'b0;
    @(negedge clk);
    // Winning miss with a rising hit: rally frozen at 1, not 2.
    bus.miss_left = 1'b1;
    bus.hit_right = 1'b1;
    expect_next("win_right", OVER, 1'b0, 4'd2, 4'd3, 8'd1, 2'b10);
    @(negedge clk);
    bus.miss_right = 1'b1;
    bus.refr_tick = 1'b1;
    expect_next("over_frozen", OVER, 1'b1, 4'd2, 4'd3, 8'd1, 2'b10);
    repeat (5) @(negedge clk);
    bus.miss_left = 1'b0;
    bus.miss_right = 1'b0;
    bus.refr_tick = 1'b0;
    bus.hit_right = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    expect_next("new_game", SERVE, 1'b1, 4'd0, 4'd0, 8'd0, 2'b00);
    @(negedge clk);
    bus.start = 1'b0;

    // Build score_l = 2, rally = 7, then reset asynchronously.
    serve_to_play(4'd0, 4'd0);
    bus.miss_right = 1'b1;
    expect_next("g2_sl1", SERVE, 1'b0, 4'd1, 4'd0, 8'd0, 2'b00);
    @(negedge clk);
    bus.miss_right = 1'b0;
    serve_to_play(4'd1, 4'd0);
    bus.miss_right = 1'b1;
    expect_next("g2_sl2", SERVE, 1'b0, 4'd2, 4'd0, 8'd0, 2'b00);
    @(negedge clk);
    bus.miss_right = 1'b0;
    serve_to_play(4'd2, 4'd0);
    for (int i = 0; i < 7; i++) begin
      bus.hit_left = 1'b1;
      if (i == 0) bus.hit_right = 1'b1;
      if (i == 0) expect_next("both_hits_one", PLAY, 1'b0, 4'd2, 4'd0, 8'd1, 2'b00);
      if (i == 6) expect_next("rally7", PLAY, 1'b0, 4'd2, 4'd0, 8'd7, 2'b00);
      @(negedge clk);
      bus.hit_left = 1'b0;
      bus.hit_right = 1'b0;
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1 compare("async_reset", actual(), {IDLE, 1'b1, 4'd0, 4'd0, 8'd0, 2'b00});
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    expect_next("after_reset", IDLE, 1'b1, 4'd0, 4'd0, 8'd0, 2'b00);
    repeat (3) @(negedge clk);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
